// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator-machine control FSM.
// Opcodes, mux/ALU encodings, state encoding and opcode class bundle.
package acc_ctrl_pkg;

  localparam int OP_LI  = 0;
  localparam int OP_MVR = 1;
  localparam int OP_LW  = 2;
  localparam int OP_SW  = 3;
  localparam int OP_ADD = 4;
  localparam int OP_SUB = 5;
  localparam int OP_AND = 6;
  localparam int OP_OR  = 7;

  localparam logic [1:0] SRC_RA  = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_MDR = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd3;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic imm;
    logic ra;
    logic load;
    logic store;
    logic alu;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational opcode classifier for the accumulator control FSM.
// Produces a one-hot class bundle consumed by next-state and output logic.
module acc_ctrl_decode
  import acc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] op,
  output op_class_t           cls
);

  always_comb begin
    cls = '0;
    unique case (op)
      OPCODE_W'(OP_LI):  cls.imm   = 1'b1;
      OPCODE_W'(OP_MVR): cls.ra    = 1'b1;
      OPCODE_W'(OP_LW):  cls.load  = 1'b1;
      OPCODE_W'(OP_SW):  cls.store = 1'b1;
      OPCODE_W'(OP_ADD),
      OPCODE_W'(OP_SUB),
      OPCODE_W'(OP_AND),
      OPCODE_W'(OP_OR):  cls.alu   = 1'b1;
      default:           cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_ctrl_fsm.sv
// Multi-cycle control FSM for a simple accumulator machine.
// Optional ACC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT.
module acc_ctrl_fsm
  import acc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                AccWrite,
  output logic [1:0]          AccSrc,
  output logic [1:0]          ALUOp,
  output logic                Illegal
);

  state_t              state;
  state_t              state_n;
  logic [OPCODE_W-1:0] op_q;
  logic [OPCODE_W-1:0] op_eff;
  op_class_t           cls;

  // DECODE classifies the live field; later states use the latched copy
  assign op_eff = (state == S_DECODE) ? Opcode : op_q;

  acc_ctrl_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .op (op_eff),
    .cls(cls)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE)
        op_q <= Opcode;
    end
  end

  always_comb begin
    state_n  = state;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    AccWrite = 1'b0;
    AccSrc   = SRC_RA;
    ALUOp    = ALU_ADD;
    Illegal  = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          cls.imm,
          cls.ra:    state_n = S_WB;
          cls.load,
          cls.store: state_n = S_MEM;
          cls.alu:   state_n = S_EXEC;
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
          cls.illegal: state_n = S_HALT;
`else
          cls.illegal: state_n = S_FETCH;
`endif
          default:   state_n = S_FETCH;
        endcase
      end
      S_EXEC: begin
        ALUOp   = op_q[1:0];
        state_n = S_WB;
      end
      S_MEM: begin
        MemWrite = cls.store;
        MemRead  = !cls.store;
        if (MemReady)
          state_n = cls.store ? S_FETCH : S_WB;
      end
      S_WB: begin
        AccWrite = 1'b1;
        state_n  = S_FETCH;
        unique case (1'b1)
          cls.imm:  AccSrc = SRC_IMM;
          cls.load: AccSrc = SRC_MDR;
          cls.alu: begin
            AccSrc = SRC_ALU;
            ALUOp  = op_q[1:0];
          end
          default:  AccSrc = SRC_RA;
        endcase
      end
      S_HALT: begin
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
        Illegal = 1'b1;
        state_n = S_HALT;
`else
        state_n = S_FETCH;
`endif
      end
      default: state_n = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Scoreboard bench for acc_ctrl_fsm: driver queues per-cycle
// expected outputs, a negedge monitor pops and compares them.
module tb_acc_ctrl_fsm;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Opcode = '0;
  logic       MemReady = 1'b0;
  logic       MemRead, MemWrite, IRWrite, PCWrite;
  logic       AccWrite, Illegal;
  logic [1:0] AccSrc, ALUOp;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [10:0] v;
    string       name;
  } exp_t;

  exp_t q[$];

  acc_ctrl_fsm #(.OPCODE_W(4)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Opcode  (Opcode),
    .MemReady(MemReady),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .IRWrite (IRWrite),
    .PCWrite (PCWrite),
    .AccWrite(AccWrite),
    .AccSrc  (AccSrc),
    .ALUOp   (ALUOp),
    .Illegal (Illegal)
  );

  always #5 CLK = ~CLK;

  // {MemRead,MemWrite,IRWrite,PCWrite,AccWrite,AccSrc,ALUOp,Illegal}
  function automatic logic [10:0] mk(
    input logic mr, input logic mw, input logic ir, input logic pc,
    input logic aw, input logic [1:0] src, input logic [1:0] alu,
    input logic ill);
    return {mr, mw, ir, pc, aw, src, alu, ill};
  endfunction

  task automatic step(input logic rst, input logic [3:0] op,
                      input logic rdy, input logic [10:0] e,
                      input string name);
    exp_t x;
    @(posedge CLK);
    #1;
    Reset    = rst;
    Opcode   = op;
    MemReady = rdy;
    x.v      = e;
    x.name   = name;
    q.push_back(x);
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [10:0] act;
      x   = q.pop_front();
      act = {MemRead, MemWrite, IRWrite, PCWrite, AccWrite,
             AccSrc, ALUOp, Illegal};
      tests++;
      if (act !== x.v) begin
        fails++;
        $display("FAIL %s: got %b expected %b", x.name, act, x.v);
      end
      tests++;
      if (MemRead && MemWrite) begin
        fails++;
        $display("FAIL %s_excl: got rd=%b wr=%b expected not both",
                 x.name, MemRead, MemWrite);
      end
    end
  end

  logic [10:0] F_WAIT, F_DONE, ZERO;

  initial begin
    F_WAIT = mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    F_DONE = mk(1, 0, 1, 1, 0, 2'd0, 2'd0, 0);
    ZERO   = '0;

    @(posedge CLK);
    #1;
    step(1, 4'd0, 0, F_WAIT, "reset_state");
    step(1, 4'd0, 1, F_DONE, "reset_hold_rdy");

    // LI: 3 cycles, opcode changed after DECODE must not matter
    step(0, 4'd0, 1, F_DONE, "li_fetch");
    step(0, 4'd0, 1, ZERO, "li_decode");
    step(0, 4'hF, 1, mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 0), "li_wb");

    // MVR with a fetch wait
    step(0, 4'd1, 0, F_WAIT, "mvr_fetch_wait");
    step(0, 4'd1, 1, F_DONE, "mvr_fetch");
    step(0, 4'd1, 1, ZERO, "mvr_decode");
    step(0, 4'd7, 0, mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 0), "mvr_wb");

    // SUB: 4 cycles
    step(0, 4'd0, 1, F_DONE, "sub_fetch");
    step(0, 4'd5, 1, ZERO, "sub_decode");
    step(0, 4'd0, 1, mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 0), "sub_exec");
    step(0, 4'd0, 1, mk(0, 0, 0, 0, 1, 2'd3, 2'd1, 0), "sub_wb");

    // OR
    step(0, 4'd0, 1, F_DONE, "or_fetch");
    step(0, 4'd7, 1, ZERO, "or_decode");
    step(0, 4'd2, 1, mk(0, 0, 0, 0, 0, 2'd0, 2'd3, 0), "or_exec");
    step(0, 4'd2, 1, mk(0, 0, 0, 0, 1, 2'd3, 2'd3, 0), "or_wb");

    // LW with three wait cycles in MEM
    step(0, 4'd0, 1, F_DONE, "lw_fetch");
    step(0, 4'd2, 1, ZERO, "lw_decode");
    step(0, 4'd3, 0, F_WAIT, "lw_mem_w1");
    step(0, 4'd3, 0, F_WAIT, "lw_mem_w2");
    step(0, 4'd3, 0, F_WAIT, "lw_mem_w3");
    step(0, 4'd3, 1, F_WAIT, "lw_mem_done");
    step(0, 4'd3, 0, mk(0, 0, 0, 0, 1, 2'd2, 2'd0, 0), "lw_wb");
    step(0, 4'd0, 0, F_WAIT, "lw_back_fetch");

    // SW with one wait cycle
    step(0, 4'd0, 1, F_DONE, "sw_fetch");
    step(0, 4'd3, 1, ZERO, "sw_decode");
    step(0, 4'd2, 0, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 0), "sw_mem_wait");
    step(0, 4'd2, 1, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 0), "sw_mem_done");
    step(0, 4'd0, 0, F_WAIT, "sw_back_fetch");

    // Reset in second MEM wait cycle of LW
    step(0, 4'd0, 1, F_DONE, "rlw_fetch");
    step(0, 4'd2, 1, ZERO, "rlw_decode");
    step(0, 4'd2, 0, F_WAIT, "rlw_mem_w1");
    step(1, 4'd2, 0, F_WAIT, "rlw_mem_w2_rst");
    step(0, 4'd2, 0, F_WAIT, "rlw_after_rst");
    step(0, 4'd2, 1, F_DONE, "rlw_refetch");
    step(0, 4'd4, 1, ZERO, "add_decode");
    step(0, 4'd4, 1, ZERO, "add_exec");
    step(0, 4'd4, 1, mk(0, 0, 0, 0, 1, 2'd3, 2'd0, 0), "add_wb");

    // Illegal opcode 12
    step(0, 4'd0, 1, F_DONE, "ill_fetch");
    step(0, 4'd12, 1, ZERO, "ill_decode");
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
    step(0, 4'd0, 1, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 1), "halt_1");
    step(0, 4'd0, 1, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 1), "halt_2");
    step(1, 4'd0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 1), "halt_rst");
    step(0, 4'd0, 0, F_WAIT, "halt_exit");
`else
    step(0, 4'd0, 0, F_WAIT, "ill_nop_fetch");
    step(0, 4'd0, 1, F_DONE, "ill_nop_fetch_done");
`endif

    for (int i = 0; i < 4 && q.size() > 0; i++)
      @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
